thor2022_insn_queue: RTL and testbench
======================================

Name: thor2022_insn_queue

Overview:
Small instruction buffer between the Thor2022 fetch stage and the decode stage. It stores fetched instruction/PC pairs in a circular buffer, each entry with a VAL/INV valid flag, and presents the oldest valid entry to decode. Fetch and decode use valid/ready handshakes. A flush on branch-taken or exception invalidates all entries in one cycle.

Parameters:
DEP, 8, queue depth in entries; power of 2, 2..32
IW, 40, instruction width in bits
PCW, 32, PC width in bits
CW, $clog2(DEP)+1, count width (derived; not overridden)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  invalidate all entries, reset pointers
fv_i  in  1  fetch presents valid instruction
finsn_i  in  IW  fetched instruction
fpc_i  in  PCW  PC of fetched instruction
frdy_o  out  1  queue can accept (not full)
dv_o  out  1  head entry valid for decode
dinsn_o  out  IW  head instruction
dpc_o  out  PCW  head PC
dack_i  in  1  decode consumes head this cycle
cnt_o  out  CW  number of valid entries
empty_o  out  1  cnt_o == 0
full_o  out  1  cnt_o == DEP

Behaviour:
- Clock clk_i; reset rst_i is synchronous and active-high; all state updates on the rising edge of clk_i.
- Reset: all entry valid flags INV, rd/wr pointers 0, cnt_o 0, frdy_o TRUE, dv_o FALSE, empty_o TRUE, full_o FALSE. dinsn_o and dpc_o read 0 (storage cleared).
- Storage: DEP entries of {valid, insn, pc}. Pointers are log2(DEP) bits and wrap modulo DEP with no special case at the wrap.
- Push: fv_i & frdy_o writes the entry at wr_ptr, sets its flag VAL, and increments wr_ptr.
  - frdy_o = !full_o. It is registered-state derived only and has no combinational path from dack_i.
- Pop: dack_i & dv_o clears the head flag to INV and increments rd_ptr.
  - dack_i while dv_o is FALSE is ignored.
- Outputs: dv_o, dinsn_o and dpc_o are driven combinationally from the entry at rd_ptr (registered storage).
- Latency: an entry pushed in cycle N is visible on dv_o in cycle N+1.
- Count: cnt_o +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full: push is blocked. A pop in the same cycle is still accepted, and frdy_o rises the next cycle.
- Empty with push in the same cycle: the new entry appears next cycle. dack_i is ignored unless the optional feature is enabled.
- Flush has priority over push and pop in the same cycle:
  - all flags go INV, pointers 0, cnt_o 0;
  - any push or pop in that cycle is discarded;
  - dv_o is FALSE the following cycle.
- Reset mid-operation behaves as a flush and also clears storage contents. Reset has priority over flush.
- Invariant: cnt_o equals the number of VAL flags at all times. It never exceeds DEP and never underflows.

Optional Feature:
Macro THOR2022_IQ_BYPASS_EN.
- Defined: when the queue is empty and fv_i is TRUE:
  - dv_o/dinsn_o/dpc_o are driven combinationally from fv_i/finsn_i/fpc_i.
  - If dack_i is also TRUE that cycle, the instruction passes straight through: nothing is written and cnt_o stays 0.
  - If dack_i is FALSE, the instruction is written normally.
  - Flush still blocks the bypass.
- Undefined: no fetch-to-decode combinational path; minimum latency is 1 cycle as stated above.

Test Plan:
- Reset, then push 8 entries (pc 0x100..0x11C, insn = pc) with dack_i=0 -> cnt_o=8, full_o=1, frdy_o=0; a 9th push (pc 0x120) is not stored.
- From full, assert dack_i for 8 cycles -> dpc_o sequence 0x100..0x11C in order, then dv_o=0, empty_o=1, cnt_o=0.
- With 3 entries held, push and pop together for 20 cycles (pointers wrap twice) -> cnt_o stays 3, output order matches input order, no entry lost or duplicated.
- With 5 entries, assert flush_i together with fv_i and dack_i -> next cycle cnt_o=0, dv_o=0, rd/wr pointers 0; the flushed-cycle push is absent from later output.
- With 4 entries, pulse rst_i for 1 cycle mid-stream -> next cycle all reset values hold; a subsequent push of pc 0x200 appears as the first dpc_o.
- THOR2022_IQ_BYPASS_EN defined, empty queue, fv_i=1 (pc 0x300) with dack_i=1 -> dv_o=1 and dpc_o=0x300 in the same cycle, cnt_o stays 0. With the macro undefined, the same stimulus gives dv_o=0 that cycle and dpc_o=0x300 with cnt_o=1 the next cycle.

Source files
------------

// File: rtl/thor2022_insn_queue.sv
// Fetch-to-decode instruction queue: DEP-entry circular buffer of {valid, insn, pc}; flush empties it in one cycle.
// Latency 1 cycle push-to-dv_o; `define THOR2022_IQ_BYPASS_EN adds a 0-cycle fetch-to-decode pass-through when empty.
// Backpressure: frdy_o = !full_o from registered count only; a pop while full is accepted and frdy_o rises next cycle.
module thor2022_insn_queue #(
  parameter int DEP = 8,
  parameter int IW  = 40,
  parameter int PCW = 32,
  localparam int CW = $clog2(DEP) + 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           fv_i,
  input  logic [IW-1:0]  finsn_i,
  input  logic [PCW-1:0] fpc_i,
  output logic           frdy_o,
  output logic           dv_o,
  output logic [IW-1:0]  dinsn_o,
  output logic [PCW-1:0] dpc_o,
  input  logic           dack_i,
  output logic [CW-1:0]  cnt_o,
  output logic           empty_o,
  output logic           full_o
);

  localparam int AW = $clog2(DEP);

  typedef struct packed {
    logic           vld;
    logic [IW-1:0]  insn;
    logic [PCW-1:0] pc;
  } entry_t;

  entry_t         mem [DEP];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  cnt;
  entry_t         head;
  logic           byp_take;
  logic           push, pop;

  assign head    = mem[rd_ptr];
  assign cnt_o   = cnt;
  assign empty_o = (cnt == '0);
  assign full_o  = (cnt == CW'(DEP));
  assign frdy_o  = !full_o;

  always_comb begin
    dv_o     = head.vld;
    dinsn_o  = head.insn;
    dpc_o    = head.pc;
    byp_take = 1'b0;
`ifdef THOR2022_IQ_BYPASS_EN
    // Empty queue: present the fetched instruction directly; consumed in-cycle means it is never stored.
    if (empty_o && fv_i && !flush_i) begin
      dv_o     = 1'b1;
      dinsn_o  = finsn_i;
      dpc_o    = fpc_i;
      byp_take = dack_i;
    end
`endif
  end

  // Pop only acts on a stored entry; a bypassed instruction never touches the pointers.
  assign push = fv_i && frdy_o && !byp_take;
  assign pop  = dack_i && head.vld;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEP; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEP; i++) mem[i].vld <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{vld: 1'b1, insn: finsn_i, pc: fpc_i};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        mem[rd_ptr].vld <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_thor2022_insn_queue.sv
// Directed bench for thor2022_insn_queue: fill/drain, wrap, flush, mid-stream reset and the bypass path.
module tb_thor2022_insn_queue;

  localparam int DEP = 8;
  localparam int IW  = 40;
  localparam int PCW = 32;
  localparam int CW  = $clog2(DEP) + 1;

  logic           clk = 1'b0;
  logic           rst_i, flush_i, fv_i, dack_i;
  logic [IW-1:0]  finsn_i;
  logic [PCW-1:0] fpc_i;
  logic           frdy_o, dv_o, empty_o, full_o;
  logic [IW-1:0]  dinsn_o;
  logic [PCW-1:0] dpc_o;
  logic [CW-1:0]  cnt_o;

  int errors = 0;
  int checks = 0;

  thor2022_insn_queue #(.DEP(DEP), .IW(IW), .PCW(PCW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .fv_i(fv_i), .finsn_i(finsn_i), .fpc_i(fpc_i), .frdy_o(frdy_o),
    .dv_o(dv_o), .dinsn_o(dinsn_o), .dpc_o(dpc_o), .dack_i(dack_i),
    .cnt_o(cnt_o), .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic v, input logic [PCW-1:0] pc);
    fv_i    = v;
    fpc_i   = pc;
    finsn_i = IW'(pc);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    checks++; if (cnt_o !== 4'd0)   begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty_o); end
    checks++; if (full_o !== 1'b0)  begin errors++; $display("FAIL reset_full: got %b want 0", full_o); end
    checks++; if (frdy_o !== 1'b1)  begin errors++; $display("FAIL reset_frdy: got %b want 1", frdy_o); end
    checks++; if (dv_o !== 1'b0)    begin errors++; $display("FAIL reset_dv: got %b want 0", dv_o); end
    checks++; if (dpc_o !== 32'h0 || dinsn_o !== 40'h0)
      begin errors++; $display("FAIL reset_data: got pc=%h insn=%h want 0", dpc_o, dinsn_o); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      set_fetch(1'b1, 32'h100 + 32'(4 * i));
      tick();
      checks++; if (cnt_o !== 4'(i + 1))
        begin errors++; $display("FAIL fill_cnt[%0d]: got %0d want %0d", i, cnt_o, i + 1); end
    end
    #1;
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full_o); end
    checks++; if (frdy_o !== 1'b0) begin errors++; $display("FAIL fill_frdy: got %b want 0", frdy_o); end
    set_fetch(1'b1, 32'h120);
    tick();
    set_fetch(1'b0, 32'h0);
    checks++; if (cnt_o !== 4'd8) begin errors++; $display("FAIL ninth_push_cnt: got %0d want 8", cnt_o); end
  endtask

  task automatic test_drain();
    dack_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (dv_o !== 1'b1 || dpc_o !== 32'h100 + 32'(4 * i) || dinsn_o !== 40'h100 + 40'(4 * i))
        begin errors++; $display("FAIL drain_order[%0d]: got dv=%b pc=%h want dv=1 pc=%h", i, dv_o, dpc_o, 32'h100 + 32'(4 * i)); end
      tick();
      if (i == 0) begin
        checks++; if (frdy_o !== 1'b1) begin errors++; $display("FAIL drain_frdy_rise: got %b want 1", frdy_o); end
      end
    end
    dack_i = 1'b0;
    #1;
    checks++; if (dv_o !== 1'b0)    begin errors++; $display("FAIL drain_dv: got %b want 0", dv_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty_o); end
    checks++; if (cnt_o !== 4'd0)   begin errors++; $display("FAIL drain_cnt: got %0d want 0", cnt_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      set_fetch(1'b1, 32'h400 + 32'(4 * i));
      tick();
    end
    dack_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_fetch(1'b1, 32'h40C + 32'(4 * i));
      #1;
      checks++; if (dv_o !== 1'b1 || dpc_o !== 32'h400 + 32'(4 * i))
        begin errors++; $display("FAIL b2b_order[%0d]: got dv=%b pc=%h want pc=%h", i, dv_o, dpc_o, 32'h400 + 32'(4 * i)); end
      tick();
      checks++; if (cnt_o !== 4'd3)
        begin errors++; $display("FAIL b2b_cnt[%0d]: got %0d want 3", i, cnt_o); end
    end
    set_fetch(1'b0, 32'h0);
    for (int i = 20; i < 23; i++) begin
      #1;
      checks++; if (dv_o !== 1'b1 || dpc_o !== 32'h400 + 32'(4 * i))
        begin errors++; $display("FAIL b2b_tail[%0d]: got dv=%b pc=%h want pc=%h", i, dv_o, dpc_o, 32'h400 + 32'(4 * i)); end
      tick();
    end
    dack_i = 1'b0;
    #1;
    checks++; if (empty_o !== 1'b1 || dv_o !== 1'b0)
      begin errors++; $display("FAIL b2b_empty: got empty=%b dv=%b want 1/0", empty_o, dv_o); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      set_fetch(1'b1, 32'h500 + 32'(4 * i));
      tick();
    end
    flush_i = 1'b1;
    dack_i  = 1'b1;
    set_fetch(1'b1, 32'h600);
    tick();
    flush_i = 1'b0;
    dack_i  = 1'b0;
    set_fetch(1'b0, 32'h0);
    #1;
    checks++; if (cnt_o !== 4'd0 || dv_o !== 1'b0 || empty_o !== 1'b1)
      begin errors++; $display("FAIL flush_state: got cnt=%0d dv=%b empty=%b want 0/0/1", cnt_o, dv_o, empty_o); end
    set_fetch(1'b1, 32'h700);
    tick();
    set_fetch(1'b0, 32'h0);
    #1;
    checks++; if (dv_o !== 1'b1 || dpc_o !== 32'h700 || cnt_o !== 4'd1)
      begin errors++; $display("FAIL flush_next_push: got dv=%b pc=%h cnt=%0d want 1/700/1", dv_o, dpc_o, cnt_o); end
    dack_i = 1'b1;
    tick();
    dack_i = 1'b0;
    #1;
    checks++; if (empty_o !== 1'b1 || dv_o !== 1'b0)
      begin errors++; $display("FAIL flush_no_ghost: got empty=%b dv=%b pc=%h want 1/0", empty_o, dv_o, dpc_o); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      set_fetch(1'b1, 32'h800 + 32'(4 * i));
      tick();
    end
    set_fetch(1'b0, 32'h0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    checks++; if (cnt_o !== 4'd0 || dv_o !== 1'b0 || frdy_o !== 1'b1 || full_o !== 1'b0 || empty_o !== 1'b1)
      begin errors++; $display("FAIL midrst_flags: got cnt=%0d dv=%b frdy=%b full=%b empty=%b", cnt_o, dv_o, frdy_o, full_o, empty_o); end
    checks++; if (dpc_o !== 32'h0 || dinsn_o !== 40'h0)
      begin errors++; $display("FAIL midrst_data: got pc=%h insn=%h want 0", dpc_o, dinsn_o); end
    set_fetch(1'b1, 32'h200);
    tick();
    set_fetch(1'b0, 32'h0);
    #1;
    checks++; if (dv_o !== 1'b1 || dpc_o !== 32'h200)
      begin errors++; $display("FAIL midrst_first: got dv=%b pc=%h want 1/200", dv_o, dpc_o); end
    dack_i = 1'b1;
    tick();
    dack_i = 1'b0;
  endtask

  task automatic test_bypass();
    set_fetch(1'b1, 32'h300);
    dack_i = 1'b1;
    #1;
`ifdef THOR2022_IQ_BYPASS_EN
    checks++; if (dv_o !== 1'b1 || dpc_o !== 32'h300)
      begin errors++; $display("FAIL bypass_same_cycle: got dv=%b pc=%h want 1/300", dv_o, dpc_o); end
    tick();
    set_fetch(1'b0, 32'h0);
    dack_i = 1'b0;
    #1;
    checks++; if (cnt_o !== 4'd0 || dv_o !== 1'b0)
      begin errors++; $display("FAIL bypass_not_stored: got cnt=%0d dv=%b want 0/0", cnt_o, dv_o); end
`else
    checks++; if (dv_o !== 1'b0)
      begin errors++; $display("FAIL nobypass_same_cycle: got dv=%b want 0", dv_o); end
    tick();
    set_fetch(1'b0, 32'h0);
    dack_i = 1'b0;
    #1;
    checks++; if (dv_o !== 1'b1 || dpc_o !== 32'h300 || cnt_o !== 4'd1)
      begin errors++; $display("FAIL nobypass_next: got dv=%b pc=%h cnt=%0d want 1/300/1", dv_o, dpc_o, cnt_o); end
    dack_i = 1'b1;
    tick();
    dack_i = 1'b0;
`endif
  endtask

  initial begin
    rst_i   = 1'b1;
    flush_i = 1'b0;
    dack_i  = 1'b0;
    set_fetch(1'b0, 32'h0);
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
